// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK1  = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_ACK2  = 3'd3,
    ST_WAIT3 = 3'd4,
    ST_ACK3  = 3'd5
  } inta_state_t;

  localparam logic [7:0] CALL_OPCODE_DEF = 8'hCD;
  localparam logic [2:0] SPURIOUS_LEVEL  = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] lvl);
    logic [7:0] r;
    r = 8'h00;
    r[lvl] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pic_inta_edge_detect.sv
// Synchronizes the asynchronous INTA_n pin and produces registered
// single-cycle fall/rise flags, SYNC_STAGES+1 clocks after the pin edge.
module pic_inta_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inta_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fall_q;
  logic                   rise_q;

  // Synchronizer chain preset to 1 (INTA_n idle) plus registered edge flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
      rise_q <= ~prev_q & sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// INTA responder: walks the 2-pulse (8086) or 3-pulse (8080/85) acknowledge
// protocol, sets/clears ISR bits and supplies CALL/vector bytes to the bus.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CALL_OPCODE = CALL_OPCODE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INTA_n,
  input  logic       int_valid,
  input  logic [2:0] int_level,
  input  logic       mode_8086,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  input  logic [2:0] addr_lo_cfg,
  input  logic       addr_interval4,
  input  logic [7:0] addr_hi,
  output logic       freeze,
  output logic [7:0] isr_set,
  output logic [7:0] isr_clr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy
);

  logic fall, rise;

  pic_inta_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk      (clk),
    .rst      (rst),
    .inta_n_i (INTA_n),
    .fall_o   (fall),
    .rise_o   (rise)
  );

  inta_state_t state_q, state_d;
  logic [2:0]  lvl_q, lvl_d;
  logic        spurious_q, spurious_d;
  logic        mode_q, mode_d;
  logic        aeoi_q, aeoi_d;
  logic [4:0]  vbase_q, vbase_d;
  logic [2:0]  addr_lo_q, addr_lo_d;
  logic        adi_q, adi_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic        freeze_q, freeze_d;
  logic        busy_q, busy_d;
  logic [7:0]  isr_set_q, isr_set_d;
  logic [7:0]  isr_clr_q, isr_clr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic [7:0]  ack2_byte;
  logic        end_seq;

  // Second-pulse byte, built from the configuration latched at the first fall.
  always_comb begin
    if (mode_q) begin
      ack2_byte = {vbase_q, lvl_q};
    end else if (adi_q) begin
      ack2_byte = {addr_lo_q, lvl_q, 2'b00};
    end else begin
      ack2_byte = {addr_lo_q[2:1], lvl_q, 3'b000};
    end
  end

  // Next-state and registered-output logic; edges not expected in a state are ignored.
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    spurious_d = spurious_q;
    mode_d     = mode_q;
    aeoi_d     = aeoi_q;
    vbase_d    = vbase_q;
    addr_lo_d  = addr_lo_q;
    adi_d      = adi_q;
    addr_hi_d  = addr_hi_q;
    freeze_d   = freeze_q;
    busy_d     = busy_q;
    isr_set_d  = 8'h00;
    isr_clr_d  = 8'h00;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    end_seq    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_ACK1;
          mode_d    = mode_8086;
          aeoi_d    = aeoi;
          vbase_d   = vector_base;
          addr_lo_d = addr_lo_cfg;
          adi_d     = addr_interval4;
          addr_hi_d = addr_hi;
          if (int_valid) begin
            lvl_d      = int_level;
            spurious_d = 1'b0;
            isr_set_d  = onehot8(int_level);
          end else begin
            lvl_d      = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
          freeze_d = 1'b1;
          busy_d   = 1'b1;
          if (mode_8086) begin
            data_out_d = 8'h00;
            data_oe_d  = 1'b0;
          end else begin
            data_out_d = CALL_OPCODE;
            data_oe_d  = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (rise) begin
          state_d    = ST_WAIT2;
          data_out_d = 8'h00;
          data_oe_d  = 1'b0;
        end
      end
      ST_WAIT2: begin
        if (fall) begin
          state_d    = ST_ACK2;
          data_out_d = ack2_byte;
          data_oe_d  = 1'b1;
        end
      end
      ST_ACK2: begin
        if (rise) begin
          if (mode_q) begin
            end_seq = 1'b1;
          end else begin
            state_d    = ST_WAIT3;
            data_out_d = 8'h00;
            data_oe_d  = 1'b0;
          end
        end
      end
      ST_WAIT3: begin
        if (fall) begin
          state_d    = ST_ACK3;
          data_out_d = addr_hi_q;
          data_oe_d  = 1'b1;
        end
      end
      ST_ACK3: begin
        if (rise) begin
          end_seq = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (end_seq) begin
      state_d    = ST_IDLE;
      freeze_d   = 1'b0;
      busy_d     = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = 8'h00;
      if (aeoi_q && !spurious_q) begin
        isr_clr_d = onehot8(lvl_q);
      end
    end
  end

  // State and output registers; reset aborts any sequence without an AEOI clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lvl_q      <= 3'd0;
      spurious_q <= 1'b0;
      mode_q     <= 1'b0;
      aeoi_q     <= 1'b0;
      vbase_q    <= 5'd0;
      addr_lo_q  <= 3'd0;
      adi_q      <= 1'b0;
      addr_hi_q  <= 8'h00;
      freeze_q   <= 1'b0;
      busy_q     <= 1'b0;
      isr_set_q  <= 8'h00;
      isr_clr_q  <= 8'h00;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      spurious_q <= spurious_d;
      mode_q     <= mode_d;
      aeoi_q     <= aeoi_d;
      vbase_q    <= vbase_d;
      addr_lo_q  <= addr_lo_d;
      adi_q      <= adi_d;
      addr_hi_q  <= addr_hi_d;
      freeze_q   <= freeze_d;
      busy_q     <= busy_d;
      isr_set_q  <= isr_set_d;
      isr_clr_q  <= isr_clr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign freeze   = freeze_q;
  assign busy     = busy_q;
  assign isr_set  = isr_set_q;
  assign isr_clr  = isr_clr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench: expected bytes and ISR pulses are queued as stimulus is
// driven; a monitor pops and compares them as the sequencer produces them.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       INTA_n = 1'b1;
  logic       int_valid = 1'b0;
  logic [2:0] int_level = 3'd0;
  logic       mode_8086 = 1'b1;
  logic       aeoi = 1'b0;
  logic [4:0] vector_base = 5'd0;
  logic [2:0] addr_lo_cfg = 3'd0;
  logic       addr_interval4 = 1'b1;
  logic [7:0] addr_hi = 8'h00;
  logic       freeze;
  logic [7:0] isr_set, isr_clr, data_out;
  logic       data_oe, busy;

  int tests_run = 0;
  int failed = 0;

  logic [7:0] byte_q[$];
  logic [7:0] set_q[$];
  logic [7:0] clr_q[$];
  logic       oe_prev = 1'b0;

  always #5 clk = ~clk;

  pic_inta_sequencer dut (
    .clk(clk), .rst(rst), .INTA_n(INTA_n), .int_valid(int_valid),
    .int_level(int_level), .mode_8086(mode_8086), .aeoi(aeoi),
    .vector_base(vector_base), .addr_lo_cfg(addr_lo_cfg),
    .addr_interval4(addr_interval4), .addr_hi(addr_hi),
    .freeze(freeze), .isr_set(isr_set), .isr_clr(isr_clr),
    .data_out(data_out), .data_oe(data_oe), .busy(busy)
  );

  // Monitor: sample on the falling edge, pop expectations for each output event.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (rst) begin
      oe_prev = 1'b0;
    end else begin
      if (data_oe && !oe_prev) begin
        tests_run++;
        if (byte_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_byte: got %h, none expected", data_out);
        end else begin
          exp = byte_q.pop_front();
          if (data_out !== exp) begin
            failed++;
            $display("FAIL bus_byte: got %h expected %h", data_out, exp);
          end else $display("[TB] byte %h", data_out);
        end
      end
      if (isr_set !== 8'h00) begin
        tests_run++;
        if (set_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_isr_set: got %h", isr_set);
        end else begin
          exp = set_q.pop_front();
          if (isr_set !== exp) begin
            failed++;
            $display("FAIL isr_set: got %h expected %h", isr_set, exp);
          end else $display("[TB] isr_set %h", isr_set);
        end
      end
      if (isr_clr !== 8'h00) begin
        tests_run++;
        if (clr_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_isr_clr: got %h", isr_clr);
        end else begin
          exp = clr_q.pop_front();
          if (isr_clr !== exp || busy !== 1'b0 || freeze !== 1'b0) begin
            failed++;
            $display("FAIL isr_clr: got %h busy %b freeze %b expected %h busy 0 freeze 0",
                     isr_clr, busy, freeze, exp);
          end else $display("[TB] isr_clr %h", isr_clr);
        end
      end
      if (isr_set !== 8'h00 && isr_clr !== 8'h00) begin
        tests_run++;
        failed++;
        $display("FAIL set_clr_overlap: set %h clr %h, required not both", isr_set, isr_clr);
      end
      oe_prev = data_oe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic inta_fall();
    @(posedge clk); #2 INTA_n = 1'b0;
  endtask

  task automatic inta_rise();
    @(posedge clk); #2 INTA_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    tick(4);
    tests_run++;
    if (byte_q.size() != 0 || set_q.size() != 0 || clr_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drained: pending bytes %0d set %0d clr %0d, required 0 0 0",
               name, byte_q.size(), set_q.size(), clr_q.size());
    end
    byte_q.delete(); set_q.delete(); clr_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    tests_run++;
    if ({freeze, busy, data_oe, isr_set, isr_clr, data_out} !== 27'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %h required 0",
               {freeze, busy, data_oe, isr_set, isr_clr, data_out});
    end
    #2 rst = 1'b0;
    tick(3);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || freeze !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle: busy %b freeze %b required 0 0", busy, freeze);
    end
  endtask

  // 8086 two-pulse sequence; with_aeoi selects whether an AEOI clear is expected.
  task automatic test_8086(input logic with_aeoi);
    mode_8086 = 1'b1; vector_base = 5'b01000; int_valid = 1'b1; int_level = 3'd3;
    aeoi = with_aeoi;
    set_q.push_back(8'h08);
    byte_q.push_back(8'h43);
    if (with_aeoi) clr_q.push_back(8'h08);
    inta_fall();
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (isr_set !== 8'h08 || freeze !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL set_timing: isr_set %h freeze %b busy %b required 08 1 1", isr_set, freeze, busy);
    end
    @(negedge clk);
    tests_run++;
    if (isr_set !== 8'h00 || data_oe !== 1'b0) begin
      failed++;
      $display("FAIL set_pulse_pulse1_float: isr_set %h data_oe %b required 00 0", isr_set, data_oe);
    end
    tick(3);
    inta_rise();
    tick(6);
    @(negedge clk);
    tests_run++;
    if (freeze !== 1'b1 || data_oe !== 1'b0) begin
      failed++;
      $display("FAIL wait2: freeze %b data_oe %b required 1 0", freeze, data_oe);
    end
    inta_fall();
    tick(6);
    @(negedge clk);
    tests_run++;
    if (data_oe !== 1'b1 || freeze !== 1'b1) begin
      failed++;
      $display("FAIL ack2: data_oe %b freeze %b required 1 1", data_oe, freeze);
    end
    inta_rise();
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (isr_clr !== (with_aeoi ? 8'h08 : 8'h00) || busy !== 1'b0 || freeze !== 1'b0) begin
      failed++;
      $display("FAIL end_seq: isr_clr %h busy %b freeze %b required %h 0 0",
               isr_clr, busy, freeze, with_aeoi ? 8'h08 : 8'h00);
    end
    tick(3);
    @(negedge clk);
    tests_run++;
    if (data_oe !== 1'b0 || data_out !== 8'h00) begin
      failed++;
      $display("FAIL end_bus: data_oe %b data_out %h required 0 00", data_oe, data_out);
    end
    check_drained(with_aeoi ? "aeoi_8086" : "basic_8086");
  endtask

  task automatic run_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      inta_fall(); tick(6);
      inta_rise(); tick(6);
    end
  endtask

  task automatic test_8080();
    mode_8086 = 1'b0; aeoi = 1'b0; int_valid = 1'b1; int_level = 3'd6;
    addr_interval4 = 1'b1; addr_lo_cfg = 3'b101; addr_hi = 8'h20;
    set_q.push_back(8'h40);
    byte_q.push_back(8'hCD); byte_q.push_back(8'hB8); byte_q.push_back(8'h20);
    run_pulses(3);
    check_drained("adi4_8080");
    addr_interval4 = 1'b0; addr_lo_cfg = 3'b100;
    set_q.push_back(8'h40);
    byte_q.push_back(8'hCD); byte_q.push_back(8'hB0); byte_q.push_back(8'h20);
    run_pulses(3);
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL end_8080: busy %b required 0", busy);
    end
    check_drained("adi8_8080");
  endtask

  task automatic test_spurious();
    mode_8086 = 1'b1; aeoi = 1'b1; int_valid = 1'b0; int_level = 3'd2;
    vector_base = 5'b00001;
    byte_q.push_back(8'h0F);
    run_pulses(2);
    check_drained("spurious");
  endtask

  task automatic test_latch();
    mode_8086 = 1'b1; aeoi = 1'b0; int_valid = 1'b1; int_level = 3'd2;
    vector_base = 5'b10000;
    set_q.push_back(8'h04);
    byte_q.push_back(8'h82);
    inta_fall(); tick(6);
    mode_8086 = 1'b0; int_level = 3'd5; vector_base = 5'b00111; int_valid = 1'b0;
    inta_rise(); tick(6);
    inta_fall(); tick(6);
    inta_rise(); tick(6);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL latch_protocol: busy %b required 0 after two pulses", busy);
    end
    check_drained("latch");
  endtask

  task automatic test_reset_abort();
    mode_8086 = 1'b1; aeoi = 1'b1; int_valid = 1'b1; int_level = 3'd1;
    vector_base = 5'b00010;
    set_q.push_back(8'h02);
    byte_q.push_back(8'h11);
    run_pulses(1);
    inta_fall(); tick(6);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({freeze, busy, data_oe, isr_set, isr_clr, data_out} !== 27'd0) begin
      failed++;
      $display("FAIL abort_outputs: got %h required 0",
               {freeze, busy, data_oe, isr_set, isr_clr, data_out});
    end
    INTA_n = 1'b1;
    tick(3);
    @(posedge clk); #3 rst = 1'b0;
    tick(6);
    check_drained("abort");
    mode_8086 = 1'b0; aeoi = 1'b1; int_valid = 1'b1; int_level = 3'd0;
    addr_interval4 = 1'b1; addr_lo_cfg = 3'b000; addr_hi = 8'h12;
    set_q.push_back(8'h01);
    byte_q.push_back(8'hCD); byte_q.push_back(8'h00); byte_q.push_back(8'h12);
    clr_q.push_back(8'h01);
    run_pulses(3);
    check_drained("after_abort");
  endtask

  initial begin
    test_reset();
    test_8086(1'b0);
    test_8086(1'b1);
    test_8080();
    test_spurious();
    test_latch();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
